sdf_stage_r2: RTL

- Parametrised radix-2 single-path delay-feedback (R2SDF) FFT stage, DIF ordering, one complex sample per accepted cycle.
- Successor to the fixed butterfly-plus-external-delay stage. Integrates the feedback delay memory and the internal control counter, so no external `ctrl` is needed.
- Adds frame sync, per-frame runtime scaling, stall tolerance and an output start-of-frame marker.
- Instances are cascaded with DEPTH = N/2, N/4, ..., 1 to form a full pipelined FFT.

---
 rtl/sdf_stage_r2.sv | 119 +++++++++++
 1 files changed

// File: rtl/sdf_stage_r2.sv
// Radix-2 single-path delay-feedback FFT stage (DIF), one complex sample per
// accepted cycle. Holds its own feedback delay memory and frame index counter,
// with frame resync, per-frame scaling, stall tolerance and an output
// start-of-frame marker.
module sdf_stage_r2 #(
  parameter int unsigned W_IN  = 16,
  parameter int unsigned W_OUT = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             sync_in,
  input  logic             scale,
  input  logic [W_IN-1:0]  din_re,
  input  logic [W_IN-1:0]  din_im,
  output logic             valid_out,
  output logic             sof_out,
  output logic [W_OUT-1:0] dout_re,
  output logic [W_OUT-1:0] dout_im,
  output logic             primed
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WA = W_IN + 2;

  if (W_OUT != W_IN + 1) begin : g_bad_width
    $error("sdf_stage_r2: W_OUT must equal W_IN+1");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sdf_stage_r2: DEPTH must be a power of two >= 1");
  end

  logic [CW-1:0]    cnt_q, cnt_d, idx;
  logic             primed_q, primed_d, scale_q, scale_d;
  logic             resync, phase_b, emit, sof_d;
  logic [AW-1:0]    addr;
  logic [W_OUT-1:0] mem_re [DEPTH];
  logic [W_OUT-1:0] mem_im [DEPTH];
  logic [W_OUT-1:0] rd_re, rd_im, wr_re, wr_im, res_re, res_im;

  // Widen both operands to W_IN+2, add or subtract, optionally halve (floor).
  function automatic logic [W_OUT-1:0] bfly(input logic [W_OUT-1:0] d,
                                            input logic [W_IN-1:0]  x,
                                            input logic             sub,
                                            input logic             sc);
    logic signed [WA-1:0] a, b, r;
    a = {d[W_OUT-1], d};
    b = {{2{x[W_IN-1]}}, x};
    r = sub ? (a - b) : (a + b);
    if (sc) r = r >>> 1;
    return r[W_OUT-1:0];
  endfunction

  // Frame index, phase decode, delay access and butterfly datapath.
  always_comb begin
    resync   = valid_in & sync_in & (cnt_q != '0);
    // A mid-frame sync makes this sample index 0 of a new frame.
    idx      = resync ? '0 : cnt_q;
    phase_b  = idx[CW-1];
    // Pointer always tracks the index modulo DEPTH, so it is derived from it.
    addr     = AW'(idx & CW'(DEPTH - 1));
    rd_re    = mem_re[addr];
    rd_im    = mem_im[addr];
    cnt_d    = valid_in ? (idx + CW'(1)) : cnt_q;
    scale_d  = (valid_in && idx == '0) ? scale : scale_q;
    primed_d = primed_q;
    if (resync) primed_d = 1'b0;
    else if (valid_in && phase_b) primed_d = 1'b1;
    emit     = valid_in & ((primed_q & ~resync) | phase_b);
    sof_d    = valid_in & (idx == CW'(DEPTH));
    if (phase_b) begin
      wr_re  = bfly(rd_re, din_re, 1'b1, scale_q);
      wr_im  = bfly(rd_im, din_im, 1'b1, scale_q);
      res_re = bfly(rd_re, din_re, 1'b0, scale_q);
      res_im = bfly(rd_im, din_im, 1'b0, scale_q);
    end else begin
      wr_re  = {din_re[W_IN-1], din_re};
      wr_im  = {din_im[W_IN-1], din_im};
      res_re = rd_re;
      res_im = rd_im;
    end
  end

  // Control state and registered outputs; everything holds on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      scale_q   <= 1'b0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      primed_q  <= primed_d;
      scale_q   <= scale_d;
      valid_out <= emit;
      sof_out   <= sof_d;
      if (emit) begin
        dout_re <= res_re;
        dout_im <= res_im;
      end
    end
  end

  // Feedback delay memory, read-old-data at the shared address; never cleared.
  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      mem_re[addr] <= wr_re;
      mem_im[addr] <= wr_im;
    end
  end

  assign primed = primed_q;

endmodule
